snake_game_ctrl: RTL
====================

# snake_game_ctrl

Game sequencer for the snake datapath, clocked on the VGA pixel clock. It owns the game state machine (idle, run, pause, over) and generates the single-cycle movement tick that advances the snake. It buffers button presses into a 2-deep turn queue so that quick double turns are not lost. It also counts apples into score and level, and shortens the move period as the level rises.

## Interface
Parameters:
- TICK_BASE, 2500000: move period in clocks at level 0 (10 Hz at 25 MHz).
- TICK_STEP, 250000: period reduction per level.
- TICK_MIN, 750000: period floor.
- APPLES_PER_LEVEL, 5: apples per level increment.

Ports:
- VGA_clk  in  1  sole clock.
- SWRES  in  1  asynchronous, active-low reset.
- BTNU, BTND, BTNL, BTNR  in  1 each  debounced, synchronised button levels.
- SWPAUSE  in  1  pause switch (level).
- got_apple  in  1  apple-eaten indication from apple logic.
- collided  in  1  collision flag from the snake head.
- mv_tick  out  1  one-cycle move strobe.
- dir  out  2  heading: 00 right, 01 up, 10 left, 11 down.
- grow  out  1  one-cycle length-increment strobe.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- score  out  10  apples eaten, saturating at 999.
- level  out  4  speed level, saturating at 15.

## Operation
- Reset values: state=IDLE, dir=00, mv_tick=0, grow=0, score=0, level=0. The queue is empty, the tick counter is 0 and the apple sub-counter is 0.
- Button edge detect:
  - Each button has a registered previous value; a press is a rising edge.
  - If several buttons rise in the same cycle, only one is taken, with priority U > L > D > R.
- Turn queue (2 entries, FIFO):
  - The reference direction is the newest queue entry, or dir if the queue is empty.
  - A candidate press is rejected if it equals or opposes the reference direction.
  - A press arriving when the queue is full is dropped.
  - Push and pop may occur in the same cycle. The push check uses the reference direction before the pop.
- FSM:
  - IDLE: no ticks. Any accepted press moves to RUN and is enqueued. The counter loads period-1.
  - RUN: the tick counter counts down. At 0 it reloads with the current period-1 and issues a tick.
  - RUN to PAUSE when SWPAUSE=1. In PAUSE the counter holds, there are no ticks, and presses and got_apple are ignored. The queue is held.
  - PAUSE to RUN when SWPAUSE=0. The counter resumes from its held value.
  - RUN or PAUSE to OVER when collided=1. Collision has priority over pause and over a tick in the same cycle.
  - OVER: no ticks and the queue is flushed. score, level and dir are frozen. The only exit is reset.
- Tick issue: in the counter-zero cycle, pop the queue head into dir (if non-empty) and set mv_tick=1.
- Apples:
  - got_apple counts on its rising edge, in RUN only.
  - Each counted apple: score+1 (saturating), grow=1, and the sub-counter increments.
  - When the sub-counter reaches APPLES_PER_LEVEL, it clears and level+1 (saturating).
- Period = max(TICK_BASE − level×TICK_STEP, TICK_MIN), computed at 24-bit unsigned width with no underflow (clamped before subtraction). A new period takes effect at the next reload; the current countdown is not disturbed.

## Timing
- mv_tick and the new dir are registered and appear together one cycle after the counter-zero cycle. Downstream samples both on the same edge.
- Tick spacing in uninterrupted RUN is exactly period clocks.
- grow asserts one cycle after the got_apple rising edge and lasts one cycle. score and level update in that same cycle.
- collided is registered: OVER is visible on state one cycle after collided rises. No mv_tick is emitted from that cycle onward.
- Reset asserted mid-game returns all outputs to reset values immediately (asynchronously). Reset deassertion takes effect on the next edge.
- Presses during a cycle with mv_tick=1 are queued normally.

## Test plan
Bench parameters: TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, APPLES_PER_LEVEL=2.
- Reset, press R -> state=RUN one cycle later, first mv_tick after 10 clocks, dir stays 00, then ticks every 10 clocks.
- In RUN with dir=right, press L -> rejected, dir stays 00. Press U then L within one period -> dir=01 at the next tick and 10 at the following tick. A third press while the queue is full is dropped.
- Four got_apple pulses -> score=4, four grow pulses, level=2, tick spacing becomes 8 then 6 clocks after the respective reloads. Holding got_apple high for 5 cycles counts as 1.
- Raise SWPAUSE 3 clocks into a period -> no ticks while paused, state=10. On release the next tick arrives 7 clocks later.
- Assert collided in the same cycle the counter hits 0 -> no mv_tick, state=11, dir frozen, queue flushed. Button presses have no effect.
- Assert SWRES mid-RUN -> all outputs are at reset values in the same cycle and state=IDLE.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: run/pause/over FSM, move-tick generator with level-dependent
// period, 2-deep turn queue fed by button edges, and apple score/level counters.
module snake_game_ctrl #(
  parameter int unsigned TICK_BASE        = 2500000,
  parameter int unsigned TICK_STEP        = 250000,
  parameter int unsigned TICK_MIN         = 750000,
  parameter int unsigned APPLES_PER_LEVEL = 5
) (
  input  logic       VGA_clk,
  input  logic       SWRES,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       SWPAUSE,
  input  logic       got_apple,
  input  logic       collided,
  output logic       mv_tick,
  output logic [1:0] dir,
  output logic       grow,
  output logic [1:0] state,
  output logic [9:0] score,
  output logic [3:0] level
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [23:0] BASE_W   = 24'(TICK_BASE);
  localparam logic [23:0] STEP_W   = 24'(TICK_STEP);
  localparam logic [23:0] MIN_W    = 24'(TICK_MIN);
  localparam logic [23:0] SPAN_W   = BASE_W - MIN_W;
  localparam logic [7:0]  APL_LAST = 8'(APPLES_PER_LEVEL - 1);

  state_t      st, st_nxt;
  logic [3:0]  btn_prev;
  logic [3:0]  rise;
  logic        apple_prev;
  logic        press_vld;
  logic [1:0]  cand;
  logic [1:0]  ref_dir;
  logic        push_ok;
  logic [1:0]  q0, q1;
  logic [1:0]  qcnt;
  logic [23:0] cnt;
  logic [23:0] red;
  logic [23:0] period;
  logic [23:0] reload;
  logic [7:0]  sub;
  logic        run_go;
  logic        tick_now;
  logic        apple_hit;
  logic        push;
  logic        pop;

  assign state = st;

  // Bit order U, L, D, R gives the required press priority directly.
  assign rise      = {BTNU, BTNL, BTND, BTNR} & ~btn_prev;
  assign press_vld = |rise;

  always_comb begin
    cand = 2'b00;
    if (rise[3])      cand = 2'b01;
    else if (rise[2]) cand = 2'b10;
    else if (rise[1]) cand = 2'b11;
  end

  always_comb begin
    case (qcnt)
      2'd0:    ref_dir = dir;
      2'd1:    ref_dir = q0;
      default: ref_dir = q1;
    endcase
  end

  assign push_ok = press_vld && (qcnt != 2'd2) && (cand != ref_dir) &&
                   (cand != {~ref_dir[1], ref_dir[0]});

  // Subtrahend is compared against the headroom first so the subtraction never wraps.
  assign red    = 24'(level) * STEP_W;
  assign period = (red >= SPAN_W) ? MIN_W : (BASE_W - red);
  assign reload = period - 24'd1;

  assign run_go    = (st == RUN) && !collided;
  assign tick_now  = run_go && (cnt == '0);
  assign apple_hit = run_go && got_apple && !apple_prev;
  assign push      = ((st == IDLE) || run_go) && push_ok;
  assign pop       = tick_now && (qcnt != 2'd0);

  always_ff @(posedge VGA_clk or negedge SWRES) begin
    if (!SWRES) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (press_vld) st_nxt = RUN;
      RUN:     if (collided) st_nxt = OVER;
               else if (SWPAUSE) st_nxt = PAUSE;
      PAUSE:   if (collided) st_nxt = OVER;
               else if (!SWPAUSE) st_nxt = RUN;
      default: st_nxt = OVER;
    endcase
  end

  always_ff @(posedge VGA_clk or negedge SWRES) begin
    if (!SWRES) begin
      btn_prev   <= '0;
      apple_prev <= 1'b0;
      mv_tick    <= 1'b0;
      grow       <= 1'b0;
      dir        <= 2'b00;
      cnt        <= '0;
      q0         <= 2'b00;
      q1         <= 2'b00;
      qcnt       <= '0;
      score      <= '0;
      level      <= '0;
      sub        <= '0;
    end else begin
      btn_prev   <= {BTNU, BTNL, BTND, BTNR};
      apple_prev <= got_apple;
      mv_tick    <= tick_now;
      grow       <= apple_hit;

      if ((st == IDLE) && press_vld) cnt <= reload;
      else if (run_go)               cnt <= tick_now ? reload : cnt - 24'd1;

      if (pop) dir <= q0;

      if (st_nxt == OVER) begin
        qcnt <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (qcnt == 2'd0) q0 <= cand;
            else              q1 <= cand;
            qcnt <= qcnt + 2'd1;
          end
          2'b01: begin
            q0   <= q1;
            qcnt <= qcnt - 2'd1;
          end
          2'b11:   q0 <= cand;
          default: ;
        endcase
      end

      if (apple_hit) begin
        if (score != 10'd999) score <= score + 10'd1;
        if (sub == APL_LAST) begin
          sub <= '0;
          if (level != 4'd15) level <= level + 4'd1;
        end else begin
          sub <= sub + 8'd1;
        end
      end
    end
  end

endmodule
